// File: rtl/display_pkg.sv
// Shared display definitions: frame-buffer state encodings, address width helper
// and pixel channel slice offsets (R at LSBs, then G, then B).
package display_pkg;

  localparam logic [0:0] FB_FILL    = 1'b0;
  localparam logic [0:0] FB_PENDING = 1'b1;

  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;

  function automatic int fb_addr_w(input int rows, input int columns);
    return $clog2(rows * columns);
  endfunction

  function automatic int ch_lsb(input int ch, input int bitwidth);
    return ch * bitwidth;
  endfunction

endpackage

// File: rtl/display_frame_bank.sv
// Two-bank simple dual-port RAM for one segment; bank bit is the address MSB.
// Read data registered (1 clock), write synchronous; no backpressure, no reset.
module display_frame_bank #(
  parameter int aw = 8,
  parameter int dw = 24
) (
  input  logic          clk,
  input  logic          we,
  input  logic [aw:0]   wr_addr,
  input  logic [dw-1:0] wr_data,
  input  logic [aw:0]   rd_addr,
  output logic [dw-1:0] rd_data
);

  logic [dw-1:0] mem [2**(aw+1)];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/display_frame_buffer.sv
// Double-buffered pixel store: front bank read with 1-clock latency, back bank filled
// via valid/ready; wr_ready drops while a commit waits for frame_complete to swap.
module display_frame_buffer
  import display_pkg::*;
#(
  parameter int segments = 1,
  parameter int rows     = 8,
  parameter int columns  = 32,
  parameter int bitwidth = 8,
  localparam int PW = 3 * bitwidth,
  localparam int RW = $clog2(rows),
  localparam int CW = $clog2(columns),
  localparam int SW = (segments > 1) ? $clog2(segments) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [RW-1:0]          row,
  input  logic [CW-1:0]          column,
  output logic [PW*segments-1:0] pixel,
  input  logic                   frame_complete,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [SW-1:0]          wr_segment,
  input  logic [RW-1:0]          wr_row,
  input  logic [CW-1:0]          wr_column,
  input  logic [PW-1:0]          wr_data,
  input  logic                   commit,
  output logic                   commit_pending,
  output logic                   swap_done,
  output logic                   front
);

  localparam int AW = fb_addr_w(rows, columns);

  logic [0:0]    state_q, state_d;
  logic          front_q, ready_q, swap_done_q, pix_vld_q;
  logic          swap, wr_fire;
  logic [AW-1:0] rd_addr, wr_addr;

  assign rd_addr = AW'(row) * AW'(columns) + AW'(column);
  assign wr_addr = AW'(wr_row) * AW'(columns) + AW'(wr_column);

  assign swap    = (state_q == FB_PENDING) && frame_complete;
  assign wr_fire = wr_valid && ready_q;

  always_comb begin
    state_d = state_q;
    if (state_q == FB_FILL) begin
      if (commit) state_d = FB_PENDING;
    end else begin
      if (frame_complete) state_d = FB_FILL;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FB_FILL;
      front_q     <= 1'b0;
      ready_q     <= 1'b0;
      swap_done_q <= 1'b0;
      pix_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= (state_d == FB_FILL);
      swap_done_q <= swap;
      pix_vld_q   <= 1'b1;
      if (swap) front_q <= ~front_q;
    end
  end

  assign wr_ready       = ready_q;
  assign commit_pending = (state_q == FB_PENDING);
  assign swap_done      = swap_done_q;
  assign front          = front_q;

  // RAM output has no reset; pix_vld_q forces pixel to zero asynchronously in reset.
  for (genvar s = 0; s < segments; s++) begin : g_seg
    logic [PW-1:0] rd_data;

    display_frame_bank #(
      .aw(AW),
      .dw(PW)
    ) u_bank (
      .clk    (clk),
      .we     (wr_fire && (wr_segment == SW'(s))),
      .wr_addr({~front_q, wr_addr}),
      .wr_data(wr_data),
      .rd_addr({front_q, rd_addr}),
      .rd_data(rd_data)
    );

    assign pixel[PW*s +: PW] = pix_vld_q ? rd_data : '0;
  end

endmodule

// File: tb/tb_display_frame_buffer.sv
// Directed bench for display_frame_buffer: vector table plus corner-case sequences
// (commit stall, simultaneous commit/frame_complete, out-of-range writes, async reset).
module tb_display_frame_buffer;

  logic        clk;
  logic        rst;
  logic [2:0]  row;
  logic [4:0]  column;
  logic [23:0] pixel;
  logic        frame_complete;
  logic        wr_valid;
  logic        wr_ready;
  logic [0:0]  wr_segment;
  logic [2:0]  wr_row;
  logic [4:0]  wr_column;
  logic [23:0] wr_data;
  logic        commit;
  logic        commit_pending;
  logic        swap_done;
  logic        front;

  int total = 0;
  int bad   = 0;

  logic [23:0] sb1 [256];
  logic [23:0] sb2 [256];

  typedef struct {
    logic [2:0]  row;
    logic [4:0]  col;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs [6];

  display_frame_buffer #(
    .segments(1), .rows(8), .columns(32), .bitwidth(8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .row           (row),
    .column        (column),
    .pixel         (pixel),
    .frame_complete(frame_complete),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_segment    (wr_segment),
    .wr_row        (wr_row),
    .wr_column     (wr_column),
    .wr_data       (wr_data),
    .commit        (commit),
    .commit_pending(commit_pending),
    .swap_done     (swap_done),
    .front         (front)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] f1(input int a);
    logic [7:0] b;
    b = 8'(a);
    return {b, b ^ 8'h5A, ~b};
  endfunction

  function automatic logic [23:0] f2(input int a);
    logic [7:0] b;
    b = 8'(a);
    return {b ^ 8'hC3, 8'h11, b};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic [0:0] seg, input int a, input logic [23:0] d);
    wr_segment = seg;
    wr_row     = 3'(a / 32);
    wr_column  = 5'(a % 32);
    wr_data    = d;
  endtask

  task automatic readback(input string name, input int which);
    for (int a = 0; a < 256; a++) begin
      row    = 3'(a / 32);
      column = 5'(a % 32);
      tick();
      check(name, 32'(pixel), 32'((which == 1) ? sb1[a] : sb2[a]));
    end
  endtask

  task automatic pulse_swap(input string name, input logic exp_front);
    frame_complete = 1'b1;
    tick();
    frame_complete = 1'b0;
    check({name, "_front"}, 32'(front), 32'(exp_front));
    check({name, "_swap_done_hi"}, 32'(swap_done), 32'd1);
    check({name, "_pending_clr"}, 32'(commit_pending), 32'd0);
    tick();
    check({name, "_swap_done_lo"}, 32'(swap_done), 32'd0);
  endtask

  initial begin
    int cp_bad, rdy_bad, fr_bad;

    vecs[0] = '{row: 3'd2, col: 5'd5,  exp: 24'hFF0000};
    vecs[1] = '{row: 3'd0, col: 5'd0,  exp: 24'h005AFF};
    vecs[2] = '{row: 3'd7, col: 5'd31, exp: 24'hFFA500};
    vecs[3] = '{row: 3'd1, col: 5'd0,  exp: 24'h207ADF};
    vecs[4] = '{row: 3'd3, col: 5'd17, exp: 24'h712B8E};
    vecs[5] = '{row: 3'd2, col: 5'd6,  exp: 24'h461CB9};

    rst = 1'b0; row = '0; column = '0; frame_complete = 1'b0;
    wr_valid = 1'b0; wr_segment = '0; wr_row = '0; wr_column = '0;
    wr_data = '0; commit = 1'b0;

    // reset state
    #12;
    check("rst_pixel", 32'(pixel), 32'd0);
    check("rst_front", 32'(front), 32'd0);
    check("rst_pending", 32'(commit_pending), 32'd0);
    check("rst_swap_done", 32'(swap_done), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    tick();
    rst = 1'b1;
    check("rel_wr_ready_before_edge", 32'(wr_ready), 32'd0);
    tick();
    check("rel_wr_ready", 32'(wr_ready), 32'd1);
    check("rel_front", 32'(front), 32'd0);

    // fill bank 1 back-to-back; last write shares its cycle with commit
    for (int a = 0; a < 256; a++) begin
      sb1[a] = (a == 69) ? 24'hFF0000 : f1(a);
      wr_valid = 1'b1;
      set_wr(1'b0, a, sb1[a]);
      if (a == 255) commit = 1'b1;
      tick();
    end
    wr_valid = 1'b0;
    commit = 1'b0;
    check("commit_pending_set", 32'(commit_pending), 32'd1);
    check("commit_wr_ready_low", 32'(wr_ready), 32'd0);
    check("commit_front_held", 32'(front), 32'd0);
    pulse_swap("swap1", 1'b1);

    for (int i = 0; i < 6; i++) begin
      row    = vecs[i].row;
      column = vecs[i].col;
      tick();
      check($sformatf("vec%0d", i), 32'(pixel), 32'(vecs[i].exp));
    end

    // fill bank 0, interleaving out-of-range segment writes that must be dropped
    for (int a = 0; a < 256; a++) begin
      sb2[a] = f2(a);
      wr_valid = 1'b1;
      set_wr(1'b0, a, sb2[a]);
      tick();
      if (a % 16 == 15) begin
        set_wr(1'b1, a, 24'hDEAD00 | 24'(a));
        tick();
        check("oor_ready", 32'(wr_ready), 32'd1);
      end
    end
    wr_valid = 1'b0;

    // commit then stall 100 clocks with a write held valid
    commit = 1'b1;
    tick();
    commit = 1'b0;
    wr_valid = 1'b1;
    set_wr(1'b0, 0, 24'h123456);
    cp_bad = 0; rdy_bad = 0; fr_bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (commit_pending !== 1'b1) cp_bad++;
      if (wr_ready !== 1'b0) rdy_bad++;
      if (front !== 1'b1) fr_bad++;
    end
    wr_valid = 1'b0;
    check("stall_pending_bad_cycles", 32'(cp_bad), 32'd0);
    check("stall_ready_bad_cycles", 32'(rdy_bad), 32'd0);
    check("stall_front_bad_cycles", 32'(fr_bad), 32'd0);
    pulse_swap("swap2", 1'b0);
    readback("readback_bank0", 2);

    // commit and frame_complete together in FILL: no swap yet
    commit = 1'b1;
    frame_complete = 1'b1;
    tick();
    commit = 1'b0;
    frame_complete = 1'b0;
    check("simul_pending", 32'(commit_pending), 32'd1);
    check("simul_front", 32'(front), 32'd0);
    check("simul_swap_done", 32'(swap_done), 32'd0);
    row = 3'd2; column = 5'd5;
    tick();
    tick();
    check("simul_front_hold", 32'(front), 32'd0);
    check("pre_swap_pixel", 32'(pixel), 32'(f2(69)));
    frame_complete = 1'b1;
    tick();
    frame_complete = 1'b0;
    check("swap3_front", 32'(front), 32'd1);
    check("swap3_swap_done_hi", 32'(swap_done), 32'd1);
    check("swap_edge_old_bank", 32'(pixel), 32'(f2(69)));
    tick();
    check("swap3_swap_done_lo", 32'(swap_done), 32'd0);
    check("post_swap_new_bank", 32'(pixel), 32'hFF0000);

    // asynchronous reset in PENDING
    commit = 1'b1;
    tick();
    commit = 1'b0;
    check("pend_before_rst", 32'(commit_pending), 32'd1);
    rst = 1'b0;
    #1;
    check("arst_front", 32'(front), 32'd0);
    check("arst_pending", 32'(commit_pending), 32'd0);
    check("arst_pixel", 32'(pixel), 32'd0);
    check("arst_wr_ready", 32'(wr_ready), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("rerel_wr_ready", 32'(wr_ready), 32'd1);
    check("rerel_front", 32'(front), 32'd0);
    check("rerel_pending", 32'(commit_pending), 32'd0);

    wr_valid = 1'b1;
    set_wr(1'b0, 132, 24'hABCDEF);
    tick();
    wr_valid = 1'b0;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    pulse_swap("swap4", 1'b1);
    row = 3'd4; column = 5'd4;
    tick();
    check("post_rst_write", 32'(pixel), 32'hABCDEF);
    row = 3'd2; column = 5'd5;
    tick();
    check("bank_kept_over_rst", 32'(pixel), 32'hFF0000);
    row = 3'd0; column = 5'd0;
    tick();
    check("bank_kept_origin", 32'(pixel), 32'h005AFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_frame_buffer.md
# display_frame_buffer

Double-buffered pixel store that sits directly upstream of `display_driver`. It answers the driver's `row`/`column` address with a `pixel` word one clock later, read from the front bank. A producer (UART/SPI frame loader) fills the back bank through a valid/ready write port. A requested swap of front and back banks takes effect only on the driver's `frame_complete` pulse, so a displayed frame never tears.

## Interface
- `segments`, 1: number of vertically stacked panel segments read in parallel.
- `rows`, 8: addressable rows per segment.
- `columns`, 32: pixels per row.
- `bitwidth`, 8: bits per colour channel; a pixel word is `3*bitwidth` bits, with R at the LSBs, then G, then B.

Ports, clock and reset first:
- `clk`: input, 1. Single clock for all logic.
- `rst`: input, 1. Reset is asynchronous and active-low.
- `row`: input, `$clog2(rows)`. Read row address from the driver.
- `column`: input, `$clog2(columns)`. Read column address from the driver.
- `pixel`: output, `3*bitwidth*segments`. Front-bank pixels for all segments at (`row`, `column`). Segment `i` occupies bits `[3*bitwidth*i +: 3*bitwidth]`.
- `frame_complete`: input, 1. One-cycle pulse from the driver marking the frame boundary.
- `wr_valid`: input, 1. Write request.
- `wr_ready`: output, 1. High when a write can be accepted.
- `wr_segment`: input, `max(1,$clog2(segments))`. Target segment.
- `wr_row`: input, `$clog2(rows)`. Target row.
- `wr_column`: input, `$clog2(columns)`. Target column.
- `wr_data`: input, `3*bitwidth`. Pixel word.
- `commit`: input, 1. One-cycle request to present the back bank at the next frame boundary.
- `commit_pending`: output, 1. High from an accepted commit until the swap.
- `swap_done`: output, 1. One-cycle pulse in the cycle after the bank swap.
- `front`: output, 1. Index of the bank currently displayed.

## Operation
- Storage consists of two banks of `segments*rows*columns` words, each `3*bitwidth` bits wide.
  - Reads always address bank `front`.
  - Writes always address bank `~front`.
- The write is accepted on the rising edge where `wr_valid && wr_ready`.
  - A write with `wr_segment >= segments` is accepted and discarded (ready still asserts).
- The state machine has two states, `FILL` and `PENDING`. Reset state is `FILL`.
- `FILL`:
  - `wr_ready` = 1.
  - `commit` = 1 moves to `PENDING` and sets `commit_pending`.
  - `frame_complete` is ignored in this state.
- `PENDING`:
  - `wr_ready` = 0. This freezes the back bank.
  - `commit` is ignored.
  - `frame_complete` = 1 toggles `front`, clears `commit_pending` and returns to `FILL`. `swap_done` pulses in the next cycle.
- Simultaneous events:
  - `wr_valid` and `commit` in the same `FILL` cycle: the write lands, then the state moves to `PENDING`.
  - `commit` and `frame_complete` in the same `FILL` cycle: the state moves to `PENDING` and the swap waits for the next `frame_complete`.
- After a swap, the new back bank holds the frame displayed before the swap. There is no copy; the producer rewrites every pixel it needs.
- Reset, including mid-frame or mid-`PENDING`:
  - `front` = 0, state = `FILL`.
  - `pixel`, `commit_pending` and `swap_done` are 0.
  - `wr_ready` is 0 while `rst` is low and 1 from the first edge after release.
  - Bank contents are not reset.

## Timing
- Read latency is exactly 1 clock. `pixel` is registered from the address sampled on edge N and is valid after edge N+1. This matches the driver's address→bram stage.
- The read address is `row*columns + column`. The write address is `wr_row*columns + wr_column` in segment `wr_segment`. Both are unsigned and zero-extended to `$clog2(rows*columns)` bits.
- The bank swap is registered on the edge that samples `frame_complete`.
  - The first read using the new `front` is the one sampled on the following edge.
  - `row` is already 0 on that edge, so row 0 of the next frame comes from the new bank.
- Back-to-back writes sustain 1 pixel per clock in `FILL`.
- Between `commit` and `swap_done`, the minimum delay is 2 clocks. The maximum is one full driver frame.

## Structure
- Shared package `display_pkg` holds:
  - State encodings `FB_FILL` and `FB_PENDING`.
  - The address-width helper used by the driver and this block: `$clog2(rows*columns)`.
  - The bit-slice offsets of the pixel channels.
- One sub-module, `display_frame_bank`, is instantiated once per segment. It is a simple dual-port RAM covering both banks, with the bank bit as the address MSB, a registered read port and a synchronous write port, so it infers BRAM.

## Test plan
- Reset, then read (row 0, col 0): `pixel` = 0, `front` = 0, `wr_ready` = 1 one edge after `rst` goes high.
- Write 0xFF0000 to (seg 0, row 2, col 5), commit, pulse `frame_complete`. Then address row 2, col 5: `pixel` = 0xFF0000 one clock later, `front` = 1, and `swap_done` pulses once.
- Commit with no `frame_complete` for 100 clocks: `commit_pending` stays 1, `wr_ready` stays 0, `front` does not change, and a held `wr_valid` performs no write.
- `commit` and `frame_complete` in the same cycle: no swap. The next `frame_complete` swaps and `swap_done` pulses 1 cycle later.
- Write with `wr_segment` = `segments` (out of range): handshake completes and no bank changes; verify with a full readback compare against a scoreboard.
- Assert `rst` low during `PENDING`: `front` = 0, `commit_pending` = 0 and `pixel` = 0 immediately (asynchronous), not at the next edge. After release, normal `FILL` behaviour resumes.
